// File: rtl/key_matrix_scan_pkg.sv
// Shared types and constants for the 4x4 key matrix scanner.
package key_matrix_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } kms_state_e;

    localparam int KEY_W = 4;

    localparam logic [3:0] ROW_IDLE = 4'b1111;

    // Active-low row drive patterns, indexed by row number.
    localparam logic [3:0][3:0] ROW_DRV = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

endpackage

// File: rtl/key_matrix_scan_if.sv
// Keypad-side and consumer-side signals of the key matrix scanner.
interface key_matrix_scan_if;
    import key_matrix_scan_pkg::*;

    logic             ENABLE;
    logic [3:0]       COL;
    logic [3:0]       ROW;
    logic [KEY_W-1:0] KEY;
    logic             KEY_VALID;
    logic             KEY_HELD;

    modport master (
        input  ENABLE, COL,
        output ROW, KEY, KEY_VALID, KEY_HELD
    );

    modport slave (
        output ENABLE, COL,
        input  ROW, KEY, KEY_VALID, KEY_HELD
    );

endinterface

// File: rtl/key_prio_enc.sv
// Priority encoder over one scan frame: lowest pressed index wins (row 0, col 0 first).
module key_prio_enc
    import key_matrix_scan_pkg::*;
(
    input  logic [15:0]      snap,
    output logic             any,
    output logic [KEY_W-1:0] code
);

    always_comb begin
        any  = |snap;
        code = '0;
        for (int i = 15; i >= 0; i--) begin
            if (snap[i]) code = KEY_W'(i);
        end
    end

endmodule

// File: rtl/key_matrix_scan.sv
// 4x4 active-low key matrix scanner with frame-based press/release debounce.
// Define KEY_REPEAT_EN to re-strobe KEY_VALID every REPEAT_FRAMES frames while held.
module key_matrix_scan
    import key_matrix_scan_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 8,
    parameter int REPEAT_FRAMES   = 64
) (
    input  logic              CLK,
    input  logic              RST,
    key_matrix_scan_if.master kb
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_N    = CNT_W'(DEBOUNCE_FRAMES);

    if (SCAN_DIV < 2 || DEBOUNCE_FRAMES < 2 || REPEAT_FRAMES < 1) begin : g_bad_param
        $error("key_matrix_scan: parameter out of range");
    end

    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       row_idx, row_nxt;
    logic [3:0]       row_q;
    logic [15:0]      snap;
    logic             frame_tick;
    logic             sample;

    logic             any;
    logic [KEY_W-1:0] code;

    kms_state_e       state, state_nxt;
    logic [KEY_W-1:0] cand, cand_nxt;
    logic [KEY_W-1:0] key_q, key_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic             valid_q, strobe;

`ifdef KEY_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_FRAMES + 1);
    logic [REP_W-1:0] rep, rep_nxt;
`endif

    // Sample at the end of the dwell so the column lines have settled.
    assign sample  = kb.ENABLE && (div_cnt == DIV_LAST);
    assign row_nxt = sample ? row_idx + 2'd1 : row_idx;

    always_ff @(posedge CLK) begin
        if (RST) begin
            div_cnt    <= '0;
            row_idx    <= '0;
            row_q      <= ROW_IDLE;
            snap       <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= sample && (row_idx == 2'd3);
            if (kb.ENABLE) begin
                div_cnt <= sample ? '0 : div_cnt + DIV_W'(1);
                row_idx <= row_nxt;
                row_q   <= ROW_DRV[row_nxt];
                if (sample) snap[{row_idx, 2'b00} +: 4] <= ~kb.COL;
            end else begin
                row_q <= ROW_IDLE;
            end
        end
    end

    key_prio_enc u_enc (
        .snap (snap),
        .any  (any),
        .code (code)
    );

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            cand    <= '0;
            key_q   <= '0;
            cnt     <= '0;
            valid_q <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep     <= '0;
`endif
        end else begin
            state   <= state_nxt;
            cand    <= cand_nxt;
            key_q   <= key_nxt;
            cnt     <= cnt_nxt;
            valid_q <= strobe;
`ifdef KEY_REPEAT_EN
            rep     <= rep_nxt;
`endif
        end
    end

    assign cnt_inc = (cnt == DEB_N) ? cnt : cnt + CNT_W'(1);

    // FSM next state; everything moves only on frame_tick
    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        key_nxt   = key_q;
        cnt_nxt   = cnt;
        strobe    = 1'b0;
`ifdef KEY_REPEAT_EN
        rep_nxt   = (state == ST_PRESSED) ? rep : '0;
`endif
        if (frame_tick) begin
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        cand_nxt  = code;
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!any) begin
                        state_nxt = ST_IDLE;
                    end else if (code != cand) begin
                        cand_nxt = code;
                        cnt_nxt  = CNT_W'(1);
                    end else begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == DEB_N) begin
                            state_nxt = ST_PRESSED;
                            key_nxt   = cand;
                            strobe    = 1'b1;
                        end
                    end
                end
                ST_PRESSED: begin
                    if (any && code == key_q) begin
`ifdef KEY_REPEAT_EN
                        if (rep == REP_W'(REPEAT_FRAMES - 1)) begin
                            rep_nxt = '0;
                            strobe  = 1'b1;
                        end else begin
                            rep_nxt = rep + REP_W'(1);
                        end
`endif
                    end else begin
                        state_nxt = ST_RELEASE;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (any && code == key_q) begin
                        state_nxt = ST_PRESSED;
                    end else begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == DEB_N) state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs; a pending release still counts as held
    always_comb begin
        kb.ROW       = row_q;
        kb.KEY       = key_q;
        kb.KEY_VALID = valid_q;
        kb.KEY_HELD  = (state == ST_PRESSED) || (state == ST_RELEASE);
    end

endmodule

// File: doc/key_matrix_scan.md
Name: key_matrix_scan

Overview:
- Scans a 4x4 active-low key matrix and reports debounced key presses; this is the input-side counterpart of the multiplexed 4-digit display driver.
- Drives one row low at a time and samples the four column lines.
- Encodes the pressed key as a 4-bit code and debounces press/release over whole scan frames.
- Feeds a single-cycle KEY_VALID strobe plus a held code to downstream control logic.

Parameters:
- SCAN_DIV, 1000: CLK cycles each row is driven (dwell); minimum 2.
- DEBOUNCE_FRAMES, 8: consecutive identical frames required to accept a press or a release; minimum 2.
- REPEAT_FRAMES, 64: autorepeat period in frames; used only when KEY_REPEAT_EN is defined.

Ports:
- CLK  input  1  system clock
- RST  input  1  synchronous, active-high reset
- ENABLE  input  1  scan enable; low freezes scanning
- COL  input  4  column sense, active-low (pulled up externally)
- ROW  output  4  row drive, active-low one-hot
- KEY  output  4  last accepted key code, row*4+col
- KEY_VALID  output  1  one-cycle strobe when a key press is accepted
- KEY_HELD  output  1  high while the accepted key remains pressed

Behaviour:
- Reset (RST=1 at posedge): ROW=4'b1111, KEY=0, KEY_VALID=0, KEY_HELD=0, all counters 0, FSM=IDLE. Reset mid-press aborts it with no strobe.
- Scan sequencing:
  - div_cnt counts 0..SCAN_DIV-1 while ENABLE=1; row_idx advances 0→1→2→3→0 when div_cnt wraps.
  - ROW = ~(1<<row_idx), registered; the first cycle after reset release with ENABLE=1 drives 4'b1110.
- Sampling:
  - COL is sampled only at div_cnt==SCAN_DIV-1 (settling margin); ~COL is stored into snap[row_idx*4 +: 4].
  - frame_tick asserts for one cycle, the cycle after the row-3 sample.
- Frame encode: any=|snap; code = lowest set index of snap (priority: row 0 first, then col 0 first). Multi-key presses report the lowest index.
- The FSM advances only on frame_tick:
  - IDLE: if any, then cand=code, cnt=1, go to DEBOUNCE.
  - DEBOUNCE:
    - !any → IDLE.
    - any and code!=cand → cand=code, cnt=1.
    - code==cand → cnt+1. When it reaches DEBOUNCE_FRAMES, go to PRESSED, load KEY=cand, and pulse KEY_VALID on the following cycle.
  - PRESSED: KEY_HELD=1. If any and code==KEY, stay. Otherwise go to RELEASE with cnt=1.
  - RELEASE:
    - any and code==KEY → PRESSED, with no new strobe.
    - Otherwise cnt+1. At DEBOUNCE_FRAMES go to IDLE with KEY_HELD=0. KEY keeps its last value.
- Latency: KEY_VALID occurs 1 cycle after the frame_tick of the DEBOUNCE_FRAMES-th consecutive matching frame.
- Change while held: a different key during PRESSED behaves as a release, so a new press needs full release debounce, then full press debounce.
- ENABLE=0:
  - div_cnt, row_idx, snap and FSM hold; ROW=4'b1111; no frame_tick.
  - Resume continues the same row with div_cnt intact; that row's next sample is taken normally.
- Counters saturate; no wrap-around of cnt.

Optional Feature:
- KEY_REPEAT_EN defined:
  - In PRESSED, a repeat counter increments per frame_tick and is cleared on PRESSED entry.
  - At REPEAT_FRAMES it pulses KEY_VALID again with the same KEY and reloads to 0.
- Undefined: exactly one KEY_VALID per accepted press; the REPEAT_FRAMES parameter is ignored.

Decomposition:
- Shared package:
  - FSM state enum (IDLE, DEBOUNCE, PRESSED, RELEASE)
  - row one-hot constants
  - ROW_IDLE=4'b1111
  - key-code width constant (4)
- One sub-module, key_prio_enc: 16-bit snapshot → {any, code[3:0]}, combinational.
- Scan counters and FSM stay in the top.

Test Plan (SCAN_DIV=4, DEBOUNCE_FRAMES=3, frame=16 cycles):
- Press row2/col1 (COL=4'b1101 whenever ROW==4'b1011), held 10 frames → KEY=9, one KEY_VALID pulse after the 3rd frame, KEY_HELD=1.
- Same key present in frames 1, 2, absent in 3, present in 4–6 → no strobe until the end of frame 6.
- Keys row0/col3 and row1/col0 held together → KEY=3. Release, then hold row1/col0 only → new strobe with KEY=4 after release and press debounce.
- Key held, ENABLE=0 for 50 cycles → ROW=4'b1111, no strobe, KEY_HELD stays 1. Resume → no duplicate strobe.
- RST asserted in DEBOUNCE (cnt=2) → all outputs 0 next cycle. No strobe until 3 fresh frames.
- KEY_REPEAT_EN, REPEAT_FRAMES=4, key 15 held 20 frames → initial strobe, then a strobe every 4 frames (4 repeats), KEY=15.
